flag_shadow_stack: RTL and testbench

FLAG_SHADOW_STACK -- requirements
Module: flag_shadow_stack

---
 rtl/flag_pkg.sv | 10 +
 rtl/flag_bit.sv | 37 +++
 rtl/flag_shadow_stack.sv | 113 +++++++++++
 tb/tb_flag_shadow_stack.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared constants for the flag register and its interrupt shadow stack.
package flag_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;

    localparam int DEFAULT_NFLAGS = 2;
    localparam int DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/flag_bit.sv
// One flag bit: restore from the shadow stack beats clear, then set, then load.
module flag_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic dIn,
    input  logic wrEn,
    input  logic set,
    input  logic clr,
    input  logic restoreVal,
    input  logic restoreEn,
    output logic q
);

    logic qNext;

    always_comb begin
        qNext = q;
        if (restoreEn) begin
            qNext = restoreVal;
        end else if (clr) begin
            qNext = 1'b0;
        end else if (set) begin
            qNext = 1'b1;
        end else if (wrEn) begin
            qNext = dIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= qNext;
        end
    end

endmodule

// File: rtl/flag_shadow_stack.sv
// Flag register with a LIFO shadow stack saved on interrupt entry and restored on RETI.
module flag_shadow_stack
    import flag_pkg::*;
#(
    parameter int NFLAGS = DEFAULT_NFLAGS,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NFLAGS-1:0]          dIn,
    input  logic [NFLAGS-1:0]          wr_en,
    input  logic [NFLAGS-1:0]          set,
    input  logic [NFLAGS-1:0]          clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [NFLAGS-1:0]          dOut,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] flags;
    logic [DW-1:0]     depthReg;
    logic              overflowReg;
    logic              underflowReg;
    logic [NFLAGS-1:0] stackMem [DEPTH];

    logic              isFull;
    logic              isEmpty;
    logic              pushOk;
    logic              popOk;
    logic              pushWhileFull;
    logic              popWhileEmpty;
    logic [IW-1:0]     wrIdx;
    logic [IW-1:0]     rdIdx;
    logic [NFLAGS-1:0] restoreVal;

    assign isFull        = (depthReg == DW'(DEPTH));
    assign isEmpty       = (depthReg == '0);
    // push and pop together cancel: neither touches the stack
    assign pushOk        = push & ~pop & ~isFull;
    assign popOk         = pop & ~push & ~isEmpty;
    assign pushWhileFull = push & ~pop & isFull;
    assign popWhileEmpty = pop & ~push & isEmpty;

    assign wrIdx      = IW'(depthReg);
    assign rdIdx      = IW'(depthReg - DW'(1));
    assign restoreVal = stackMem[rdIdx];

    generate
        for (genvar gi = 0; gi < NFLAGS; gi++) begin : gen_flag
            flag_bit u_flag_bit (
                .clk        (clk),
                .rst_n      (rst_n),
                .dIn        (dIn[gi]),
                .wrEn       (wr_en[gi]),
                .set        (set[gi]),
                .clr        (clr[gi]),
                .restoreVal (restoreVal[gi]),
                .restoreEn  (popOk),
                .q          (flags[gi])
            );
        end
    endgenerate

    // Entries at or above depth are dead, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            stackMem[wrIdx] <= flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depthReg     <= '0;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
        end else begin
            if (pushOk) begin
                depthReg <= depthReg + DW'(1);
            end else if (popOk) begin
                depthReg <= depthReg - DW'(1);
            end

            // A fresh error outranks err_clr in the same cycle.
            if (pushWhileFull) begin
                overflowReg <= 1'b1;
            end else if (err_clr) begin
                overflowReg <= 1'b0;
            end

            if (popWhileEmpty) begin
                underflowReg <= 1'b1;
            end else if (err_clr) begin
                underflowReg <= 1'b0;
            end
        end
    end

    assign dOut      = flags;
    assign depth     = depthReg;
    assign full      = isFull;
    assign empty     = isEmpty;
    assign overflow  = overflowReg;
    assign underflow = underflowReg;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Directed and random checks of flag_shadow_stack against a queue-based reference model.
module tb_flag_shadow_stack;
    import flag_pkg::*;

    localparam int NF = 2;
    localparam int DP = 4;
    localparam int DW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] dIn = '0;
    logic [NF-1:0] wr_en = '0;
    logic [NF-1:0] set = '0;
    logic [NF-1:0] clr = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [NF-1:0] dOut;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: current flags, a queue of saved flag words, sticky errors.
    logic [NF-1:0] mFlags;
    logic [NF-1:0] mStack[$];
    bit            mOv;
    bit            mUf;

    flag_shadow_stack #(.NFLAGS(NF), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dIn       (dIn),
        .wr_en     (wr_en),
        .set       (set),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .dOut      (dOut),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mFlags = '0;
        mStack.delete();
        mOv = 1'b0;
        mUf = 1'b0;
    endtask

    task automatic modelStep();
        int            sz;
        logic [NF-1:0] old;
        sz  = mStack.size();
        old = mFlags;
        if (pop && !push && sz > 0) begin
            mFlags = mStack.pop_back();
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (clr[i])        mFlags[i] = 1'b0;
                else if (set[i])   mFlags[i] = 1'b1;
                else if (wr_en[i]) mFlags[i] = dIn[i];
            end
        end
        if (push && !pop && sz < DP) mStack.push_back(old);
        if (push && !pop && sz == DP) mOv = 1'b1;
        else if (err_clr)             mOv = 1'b0;
        if (pop && !push && sz == 0)  mUf = 1'b1;
        else if (err_clr)             mUf = 1'b0;
    endtask

    task automatic compareModel(input string tag);
        chk({tag, ".dOut"},      32'(dOut),      32'(mFlags));
        chk({tag, ".depth"},     32'(depth),     32'(mStack.size()));
        chk({tag, ".full"},      32'(full),      32'(mStack.size() == DP));
        chk({tag, ".empty"},     32'(empty),     32'(mStack.size() == 0));
        chk({tag, ".overflow"},  32'(overflow),  32'(mOv));
        chk({tag, ".underflow"}, 32'(underflow), 32'(mUf));
    endtask

    task automatic step(input string tag, input logic [NF-1:0] d, input logic [NF-1:0] w,
                        input logic [NF-1:0] s, input logic [NF-1:0] c,
                        input logic ps, input logic pp, input logic ec);
        dIn = d; wr_en = w; set = s; clr = c; push = ps; pop = pp; err_clr = ec;
        modelStep();
        @(posedge clk);
        #1;
        compareModel(tag);
        $display("step %-10s dIn=%b wr=%b set=%b clr=%b push=%b pop=%b ec=%b -> dOut=%b depth=%0d ov=%b uf=%b",
                 tag, d, w, s, c, ps, pp, ec, dOut, depth, overflow, underflow);
    endtask

    task automatic load(input string tag, input logic [NF-1:0] v);
        step(tag, v, '1, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doPush(input string tag);
        step(tag, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic doPop(input string tag);
        step(tag, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [NF-1:0] saved [5];

    initial begin
        modelReset();
        #2;
        compareModel("reset");
        chk("reset.empty_const", 32'(empty), 32'd1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Priority: clr beats set beats load on bit 0; bit 1 loads 1.
        step("prio", 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("prio.const", 32'(dOut), 32'(2'b10));

        // Two-level nesting.
        load("nest.ld01", 2'b01);
        doPush("nest.push1");
        load("nest.ld10", 2'b10);
        doPush("nest.push2");
        load("nest.ld11", 2'b11);
        doPop("nest.pop1");
        chk("nest.pop1.dOut", 32'(dOut), 32'(2'b10));
        chk("nest.pop1.depth", 32'(depth), 32'd1);
        doPop("nest.pop2");
        chk("nest.pop2.dOut", 32'(dOut), 32'(2'b01));
        chk("nest.pop2.empty", 32'(empty), 32'd1);

        // Overflow: five pushes into a four-deep stack.
        saved[0] = 2'b01; saved[1] = 2'b10; saved[2] = 2'b11; saved[3] = 2'b00; saved[4] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            load("ovf.load", saved[i]);
            doPush("ovf.push");
        end
        chk("ovf.depth", 32'(depth), 32'(DP));
        chk("ovf.full", 32'(full), 32'd1);
        chk("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 3; i >= 0; i--) begin
            doPop("ovf.pop");
            chk("ovf.restore", 32'(dOut), 32'(saved[i]));
        end
        step("ovf.clr", '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovf.cleared", 32'(overflow), 32'd0);

        // Underflow and sticky precedence over err_clr.
        load("unf.ld00", 2'b00);
        step("unf.pop", '0, '0, 2'b01, '0, 1'b0, 1'b1, 1'b0);
        chk("unf.dOut", 32'(dOut), 32'(2'b01));
        chk("unf.flag", 32'(underflow), 32'd1);
        step("unf.popclr", '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("unf.sticky", 32'(underflow), 32'd1);
        step("unf.clr", '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("unf.cleared", 32'(underflow), 32'd0);

        // Simultaneous push and pop at depth 2.
        load("sim.ld", 2'b11);
        doPush("sim.push1");
        doPush("sim.push2");
        step("sim.both", 2'b00, 2'b11, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("sim.depth", 32'(depth), 32'd2);
        chk("sim.dOut", 32'(dOut), 32'(2'b00));
        chk("sim.noerr", 32'({overflow, underflow}), 32'd0);

        // Asynchronous reset mid-nesting.
        load("rst.ld", 2'b11);
        doPush("rst.push3");
        chk("rst.depth3", 32'(depth), 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        compareModel("rst.async");
        chk("rst.dOut0", 32'(dOut), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doPop("rst.pop");
        chk("rst.underflow", 32'(underflow), 32'd1);
        step("rst.clr", '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic, with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                modelReset();
                compareModel("rnd.rst");
                #1;
                rst_n = 1'b1;
            end else begin
                step("rnd",
                     NF'($urandom), NF'($urandom & $urandom), NF'($urandom & $urandom & $urandom),
                     NF'($urandom & $urandom & $urandom),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 7) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
